// File: rtl/led_pwm_pio.sv
// led_pwm_pio: Avalon-MM slave output PIO for board LEDs, with per-channel
// 8-bit PWM dimming driven by a shared prescaler.
// DATA/OUTSET/OUTCLEAR set which LEDs are on.
// Each DUTYn register sets the brightness of channel n.
// Duty changes only take effect at the start of a PWM period, so the LED never glitches.
module led_pwm_pio #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd1;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;

  logic [WIDTH-1:0]      r_outReg;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_preCnt;
  logic [7:0]            r_pwmCnt;
  logic [7:0]            r_dutyReq [WIDTH];
  logic [7:0]            r_dutyAct [WIDTH];
  logic [31:0]           r_readdata;
  logic [WIDTH-1:0]      r_outPort;

  logic        w_write;
  logic        w_wrPrescale;
  logic        w_preMatch;
  logic        w_tick;
  logic        w_periodStart;
  logic [31:0] w_readMux;
  logic        w_unused;

  assign w_write       = chipselect & ~write_n;
  assign w_wrPrescale  = w_write & (address == ADDR_PRESCALE);
  assign w_preMatch    = (r_preCnt == r_prescale);
  // A PRESCALE write restarts the prescaler, so that edge never produces a tick.
  assign w_tick        = w_preMatch & ~w_wrPrescale;
  assign w_periodStart = w_tick & (r_pwmCnt == 8'hFF);
  // Upper write-data bits only matter for some registers; fold them so none dangle.
  assign w_unused      = &{1'b0, writedata};

  assign readdata = r_readdata;
  assign out_port = r_outPort;

  // On/off data register, with whole-word write plus bit set and bit clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outReg <= '0;
    end else if (w_write && address == ADDR_DATA) begin
      r_outReg <= writedata[WIDTH-1:0];
    end else if (w_write && address == ADDR_OUTSET) begin
      r_outReg <= r_outReg | writedata[WIDTH-1:0];
    end else if (w_write && address == ADDR_OUTCLEAR) begin
      r_outReg <= r_outReg & ~writedata[WIDTH-1:0];
    end
  end

  // Prescaler: count up to the programmed limit, then wrap and emit a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_preCnt   <= '0;
    end else if (w_wrPrescale) begin
      r_prescale <= writedata[PRESCALE_W-1:0];
      r_preCnt   <= '0;
    end else if (w_preMatch) begin
      r_preCnt <= '0;
    end else begin
      r_preCnt <= r_preCnt + PRESCALE_W'(1);
    end
  end

  // PWM phase counter, one step per tick; a full period is 256 ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwmCnt <= '0;
    end else if (w_tick) begin
      r_pwmCnt <= r_pwmCnt + 8'd1;
    end
  end

  // Software duty requests and their shadows, which are copied only at period start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < WIDTH; n++) begin
        r_dutyReq[n] <= 8'hFF;
        r_dutyAct[n] <= 8'hFF;
      end
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (w_write && address == 3'(4 + n)) begin
          r_dutyReq[n] <= writedata[7:0];
        end
        if (w_periodStart) begin
          r_dutyAct[n] <= r_dutyReq[n];
        end
      end
    end
  end

  // Registered LED drive; a duty of FF means fully on, with no off slot at count 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outPort <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        r_outPort[n] <= r_outReg[n] &
                        ((r_dutyAct[n] == 8'hFF) | (r_pwmCnt < r_dutyAct[n]));
      end
    end
  end

  // Read mux for the current address; write-only and absent registers read 0.
  always_comb begin
    w_readMux = '0;
    case (address)
      ADDR_DATA:     w_readMux[WIDTH-1:0]      = r_outReg;
      ADDR_PRESCALE: w_readMux[PRESCALE_W-1:0] = r_prescale;
      default: begin
        for (int n = 0; n < WIDTH; n++) begin
          if (address == 3'(4 + n)) begin
            w_readMux[7:0] = r_dutyReq[n];
          end
        end
      end
    endcase
  end

  // Read data is registered every cycle, regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_readMux;
    end
  end

endmodule
